// File: rtl/fuse_ctrl_edn_rsp_if.sv
`default_nettype none
// ============================================================================
// Module      : fuse_ctrl_edn_rsp_if
// Description : EDN request/response bundle between fuse_ctrl and responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface fuse_ctrl_edn_rsp_if #(
    parameter int CNT_WIDTH = 16
) ();
    logic                 edn_req_i;
    logic [7:0]           lat_i;
    logic                 stall_i;
    logic                 fips_fail_i;
    logic                 clr_err_i;
    logic                 edn_ack_o;
    logic                 edn_fips_o;
    logic [31:0]          edn_bus_o;
    logic                 busy_o;
    logic [CNT_WIDTH-1:0] ack_cnt_o;
    logic                 proto_err_o;

    // fuse_ctrl side: raises requests, consumes entropy words
    modport master (
        output edn_req_i, lat_i, stall_i, fips_fail_i, clr_err_i,
        input  edn_ack_o, edn_fips_o, edn_bus_o, busy_o, ack_cnt_o, proto_err_o
    );

    modport slave (
        input  edn_req_i, lat_i, stall_i, fips_fail_i, clr_err_i,
        output edn_ack_o, edn_fips_o, edn_bus_o, busy_o, ack_cnt_o, proto_err_o
    );
endinterface
`default_nettype wire

// File: rtl/fuse_ctrl_edn_rsp.sv
`default_nettype none
// ============================================================================
// Module      : fuse_ctrl_edn_rsp
// Description : EDN responder returning LFSR entropy words with programmable
//               latency, stall, FIPS flag, ack counter and protocol error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fuse_ctrl_edn_rsp #(
    parameter logic [31:0] LFSR_SEED    = 32'h0000_0001,
    parameter logic        FIPS_DEFAULT = 1'b1,
    parameter int          CNT_WIDTH    = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    fuse_ctrl_edn_rsp_if.slave    edn
);

    // An all-zero seed would lock the LFSR, so it is remapped to 1
    localparam logic [31:0]          c_seed    = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam logic [31:0]          c_poly    = 32'h8020_0003;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [31:0]          r_lfsr;
    logic                 r_ack;
    logic                 r_fips;
    logic [31:0]          r_bus;
    logic                 r_busy;
    logic [CNT_WIDTH-1:0] r_ack_cnt;
    logic                 r_proto_err;
    logic [31:0]          w_lfsr_next;

    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_poly) : (r_lfsr >> 1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_lfsr      <= c_seed;
            r_ack       <= 1'b0;
            r_fips      <= 1'b0;
            r_bus       <= 32'h0;
            r_busy      <= 1'b0;
            r_ack_cnt   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            // A clear is overridden by an abort on the same edge (later NBA)
            if (edn.clr_err_i) begin
                r_proto_err <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (edn.edn_req_i) begin
                        r_cnt   <= edn.lat_i;
                        r_busy  <= 1'b1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!edn.edn_req_i) begin
                        r_proto_err <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (edn.stall_i) begin
                        r_cnt <= r_cnt;
                    end else if (r_cnt == 8'd0) begin
                        r_ack   <= 1'b1;
                        r_bus   <= r_lfsr;
                        r_fips  <= FIPS_DEFAULT & ~edn.fips_fail_i;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_ACK: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_lfsr  <= w_lfsr_next;
                    r_state <= ST_IDLE;
                    if (r_ack_cnt != c_cnt_max) begin
                        r_ack_cnt <= r_ack_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign edn.edn_ack_o   = r_ack;
    assign edn.edn_fips_o  = r_fips;
    assign edn.edn_bus_o   = r_bus;
    assign edn.busy_o      = r_busy;
    assign edn.ack_cnt_o   = r_ack_cnt;
    assign edn.proto_err_o = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_fuse_ctrl_edn_rsp.sv
`default_nettype none
// ============================================================================
// Module      : tb_fuse_ctrl_edn_rsp
// Description : Directed self-checking bench for fuse_ctrl_edn_rsp.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fuse_ctrl_edn_rsp;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    fuse_ctrl_edn_rsp_if #(.CNT_WIDTH(16)) if1 ();
    fuse_ctrl_edn_rsp_if #(.CNT_WIDTH(4))  if2 ();

    fuse_ctrl_edn_rsp #(
        .LFSR_SEED(32'h0000_0001), .FIPS_DEFAULT(1'b1), .CNT_WIDTH(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .edn(if1.slave)
    );

    // Narrow counter instance; zero seed must behave like seed 1
    fuse_ctrl_edn_rsp #(
        .LFSR_SEED(32'h0000_0000), .FIPS_DEFAULT(1'b1), .CNT_WIDTH(4)
    ) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .edn(if2.slave)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    initial begin
        logic        bad;
        logic        seen;
        logic [31:0] exp_word;

        if1.edn_req_i = 1'b0; if1.lat_i = 8'd0; if1.stall_i = 1'b0;
        if1.fips_fail_i = 1'b0; if1.clr_err_i = 1'b0;
        if2.edn_req_i = 1'b0; if2.lat_i = 8'd0; if2.stall_i = 1'b0;
        if2.fips_fail_i = 1'b0; if2.clr_err_i = 1'b0;

        tick(); tick();
        rst_i = 1'b0;
        check("rst_ack",  {31'd0, if1.edn_ack_o},   32'd0);
        check("rst_fips", {31'd0, if1.edn_fips_o},  32'd0);
        check("rst_bus",  if1.edn_bus_o,            32'd0);
        check("rst_busy", {31'd0, if1.busy_o},      32'd0);
        check("rst_cnt",  {16'd0, if1.ack_cnt_o},   32'd0);
        check("rst_err",  {31'd0, if1.proto_err_o}, 32'd0);

        // Three back-to-back words at zero latency
        if1.edn_req_i = 1'b1; if1.lat_i = 8'd0;
        tick();
        check("l0_busy_e0", {31'd0, if1.busy_o},    32'd1);
        check("l0_noack_e0", {31'd0, if1.edn_ack_o}, 32'd0);
        tick();
        check("w1_ack",  {31'd0, if1.edn_ack_o},  32'd1);
        check("w1_bus",  if1.edn_bus_o,           32'h0000_0001);
        check("w1_fips", {31'd0, if1.edn_fips_o}, 32'd1);
        tick();
        check("w1_ack_low", {31'd0, if1.edn_ack_o}, 32'd0);
        check("w1_cnt", {16'd0, if1.ack_cnt_o}, 32'd1);
        tick();
        check("gap_ack_low", {31'd0, if1.edn_ack_o}, 32'd0);
        tick();
        check("w2_ack", {31'd0, if1.edn_ack_o}, 32'd1);
        check("w2_bus", if1.edn_bus_o,          32'h8020_0003);
        tick();
        check("w2_ack_low", {31'd0, if1.edn_ack_o}, 32'd0);
        tick(); tick();
        check("w3_ack",  {31'd0, if1.edn_ack_o},  32'd1);
        check("w3_bus",  if1.edn_bus_o,           32'hC030_0002);
        check("w3_fips", {31'd0, if1.edn_fips_o}, 32'd1);
        if1.edn_req_i = 1'b0;
        tick();
        check("w3_ack_low", {31'd0, if1.edn_ack_o}, 32'd0);
        check("w3_cnt",  {16'd0, if1.ack_cnt_o}, 32'd3);
        check("w3_hold", if1.edn_bus_o,          32'hC030_0002);
        check("w3_busy", {31'd0, if1.busy_o},    32'd0);

        // Latency 5 with three stalled cycles: ack after E0+9
        if1.edn_req_i = 1'b1; if1.lat_i = 8'd5;
        tick();
        if1.stall_i = 1'b1;
        bad = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) if1.stall_i = 1'b0;
            tick();
            if (i == 3) if1.stall_i = 1'b0;
            if (if1.edn_ack_o !== 1'b0 || if1.busy_o !== 1'b1) bad = 1'b1;
        end
        check("stall_wait_shape", {31'd0, bad}, 32'd0);
        tick();
        check("stall_ack_e9", {31'd0, if1.edn_ack_o}, 32'd1);
        check("stall_busy_e9", {31'd0, if1.busy_o},  32'd1);
        check("w4_bus", if1.edn_bus_o, 32'h6018_0001);
        if1.edn_req_i = 1'b0;
        tick();
        check("stall_busy_end", {31'd0, if1.busy_o}, 32'd0);
        check("w4_cnt", {16'd0, if1.ack_cnt_o}, 32'd4);

        // Abort after two cycles, then clear, then clear racing a new abort
        if1.edn_req_i = 1'b1; if1.lat_i = 8'd10;
        tick(); tick();
        if1.edn_req_i = 1'b0;
        tick();
        check("abort_err",  {31'd0, if1.proto_err_o}, 32'd1);
        check("abort_ack",  {31'd0, if1.edn_ack_o},   32'd0);
        check("abort_busy", {31'd0, if1.busy_o},      32'd0);
        check("abort_cnt",  {16'd0, if1.ack_cnt_o},   32'd4);
        if1.clr_err_i = 1'b1;
        tick();
        if1.clr_err_i = 1'b0;
        check("clr_err", {31'd0, if1.proto_err_o}, 32'd0);
        if1.edn_req_i = 1'b1;
        tick(); tick();
        if1.edn_req_i = 1'b0; if1.clr_err_i = 1'b1;
        tick();
        if1.clr_err_i = 1'b0;
        check("set_beats_clr", {31'd0, if1.proto_err_o}, 32'd1);
        if1.clr_err_i = 1'b1;
        tick();
        if1.clr_err_i = 1'b0;

        // fips_fail only on the ack edge of word 5
        if1.edn_req_i = 1'b1; if1.lat_i = 8'd2;
        tick(); tick(); tick();
        if1.fips_fail_i = 1'b1;
        tick();
        if1.fips_fail_i = 1'b0;
        check("w5_ack",  {31'd0, if1.edn_ack_o},  32'd1);
        check("w5_bus",  if1.edn_bus_o,           32'hB02C_0003);
        check("w5_fips", {31'd0, if1.edn_fips_o}, 32'd0);
        tick();
        check("w5_fips_hold", {31'd0, if1.edn_fips_o}, 32'd0);
        tick(); tick(); tick(); tick();
        check("w6_ack",  {31'd0, if1.edn_ack_o},  32'd1);
        check("w6_bus",  if1.edn_bus_o,           32'hD836_0002);
        check("w6_fips", {31'd0, if1.edn_fips_o}, 32'd1);
        if1.edn_req_i = 1'b0;
        tick();
        check("w6_cnt", {16'd0, if1.ack_cnt_o}, 32'd6);

        // Reset while waiting with cnt=3
        if1.edn_req_i = 1'b1; if1.lat_i = 8'd5;
        tick(); tick(); tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        if1.edn_req_i = 1'b0;
        check("midrst_busy", {31'd0, if1.busy_o},    32'd0);
        check("midrst_bus",  if1.edn_bus_o,          32'd0);
        check("midrst_cnt",  {16'd0, if1.ack_cnt_o}, 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if1.edn_ack_o !== 1'b0) bad = 1'b1;
        end
        check("midrst_no_ack", {31'd0, bad}, 32'd0);
        if1.edn_req_i = 1'b1; if1.lat_i = 8'd0;
        tick(); tick();
        check("midrst_ack",  {31'd0, if1.edn_ack_o}, 32'd1);
        check("midrst_word", if1.edn_bus_o,          32'h0000_0001);
        if1.edn_req_i = 1'b0;
        tick();

        // 4-bit counter saturation over 17 requests
        if2.edn_req_i = 1'b1; if2.lat_i = 8'd0;
        exp_word = 32'h0000_0001;
        for (int k = 1; k <= 17; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                if (if2.edn_ack_o === 1'b1) seen = 1'b1;
            end
            check("sat_ack_seen", {31'd0, seen}, 32'd1);
            check("sat_word", if2.edn_bus_o, exp_word);
            if (k == 15) check("sat_cnt14", {28'd0, if2.ack_cnt_o}, 32'd14);
            if (k == 17) check("sat_cnt16", {28'd0, if2.ack_cnt_o}, 32'd15);
            exp_word = lfsr_step(exp_word);
        end
        if2.edn_req_i = 1'b0;
        tick();
        check("sat_cnt17", {28'd0, if2.ack_cnt_o}, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
